// File: rtl/trdb_trace_ctrl.sv
// Trace on/off sequencing controller: issues start/stop/resync packet requests
// and the deactivate pulse back to the control register.
module trdb_trace_ctrl #(
    parameter int RESYNC_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                trace_enable_i,
    input  logic                nc_trace_qualified_i,
    input  logic                trigger_trace_off_i,
    input  logic [RESYNC_W-1:0] resync_max_i,
    input  logic                pkt_valid_i,
    input  logic                start_ack_i,
    input  logic                stop_ack_i,
    input  logic                resync_ack_i,
    input  logic                fifo_empty_i,
    output logic                trace_active_o,
    output logic                start_req_o,
    output logic                stop_req_o,
    output logic                resync_req_o,
    output logic                trace_req_deactivate_o,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        STARTING = 2'b01,
        ACTIVE   = 2'b10,
        STOPPING = 2'b11
    } state_e;

    state_e state_q, state_d;

    logic                stop_acked_q;
    logic                off_cause_q;
    logic                resync_req_q;
    logic                deactivate_q;
    logic [RESYNC_W-1:0] resync_cnt_q;
    logic [RESYNC_W-1:0] resync_cnt_inc;

    logic go;
    logic stop;
    logic enter_stopping;
    logic enter_active;
    logic count_pkt;

    assign go   = trace_enable_i & nc_trace_qualified_i & ~trigger_trace_off_i;
    assign stop = ~trace_enable_i | ~nc_trace_qualified_i | trigger_trace_off_i;

    assign enter_stopping = (state_q != STOPPING) && (state_d == STOPPING);
    assign enter_active   = (state_q != ACTIVE) && (state_d == ACTIVE);
    assign count_pkt      = pkt_valid_i && (resync_max_i != '0);
    assign resync_cnt_inc = resync_cnt_q + RESYNC_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The start packet is never aborted: a stop seen while STARTING waits for the ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go) state_d = STARTING;
            end
            STARTING: begin
                if (start_ack_i) state_d = stop ? STOPPING : ACTIVE;
            end
            ACTIVE: begin
                if (stop) state_d = STOPPING;
            end
            STOPPING: begin
                if ((stop_ack_i || stop_acked_q) && fifo_empty_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stop_acked_q <= 1'b0;
            off_cause_q  <= 1'b0;
            deactivate_q <= 1'b0;
        end else begin
            deactivate_q <= 1'b0;
            if (enter_stopping && trigger_trace_off_i) begin
                off_cause_q <= 1'b1;
            end
            if (state_q == STOPPING) begin
                if (state_d == IDLE) begin
                    stop_acked_q <= 1'b0;
                    deactivate_q <= off_cause_q;
                    off_cause_q  <= 1'b0;
                end else if (stop_ack_i) begin
                    stop_acked_q <= 1'b1;
                end
            end
        end
    end

    // A stop in the same cycle as a threshold hit suppresses the resync request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resync_cnt_q <= '0;
            resync_req_q <= 1'b0;
        end else if (enter_active) begin
            resync_cnt_q <= '0;
            resync_req_q <= 1'b0;
        end else if (state_q == ACTIVE && state_d == ACTIVE) begin
            if (resync_ack_i) begin
                resync_req_q <= 1'b0;
            end
            if (resync_max_i == '0) begin
                resync_cnt_q <= '0;
            end else if (count_pkt) begin
                if (resync_cnt_inc == resync_max_i) begin
                    resync_cnt_q <= '0;
                    resync_req_q <= 1'b1;
                end else begin
                    resync_cnt_q <= resync_cnt_inc;
                end
            end
        end else begin
            resync_req_q <= 1'b0;
        end
    end

    assign state_o                = state_q;
    assign trace_active_o         = (state_q == ACTIVE);
    assign start_req_o            = (state_q == STARTING);
    assign stop_req_o             = (state_q == STOPPING) && !stop_acked_q;
    assign resync_req_o           = resync_req_q;
    assign trace_req_deactivate_o = deactivate_q;

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// Directed self-checking bench for trdb_trace_ctrl; each task covers one scenario
// with hand-computed expectations.
module tb_trdb_trace_ctrl;

    localparam int RESYNC_W = 16;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                trace_enable_i;
    logic                nc_trace_qualified_i;
    logic                trigger_trace_off_i;
    logic [RESYNC_W-1:0] resync_max_i;
    logic                pkt_valid_i;
    logic                start_ack_i;
    logic                stop_ack_i;
    logic                resync_ack_i;
    logic                fifo_empty_i;
    logic                trace_active_o;
    logic                start_req_o;
    logic                stop_req_o;
    logic                resync_req_o;
    logic                trace_req_deactivate_o;
    logic [1:0]          state_o;

    int tests_run    = 0;
    int tests_failed = 0;

    trdb_trace_ctrl #(.RESYNC_W(RESYNC_W)) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .trace_enable_i         (trace_enable_i),
        .nc_trace_qualified_i   (nc_trace_qualified_i),
        .trigger_trace_off_i    (trigger_trace_off_i),
        .resync_max_i           (resync_max_i),
        .pkt_valid_i            (pkt_valid_i),
        .start_ack_i            (start_ack_i),
        .stop_ack_i             (stop_ack_i),
        .resync_ack_i           (resync_ack_i),
        .fifo_empty_i           (fifo_empty_i),
        .trace_active_o         (trace_active_o),
        .start_req_o            (start_req_o),
        .stop_req_o             (stop_req_o),
        .resync_req_o           (resync_req_o),
        .trace_req_deactivate_o (trace_req_deactivate_o),
        .state_o                (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic goto_active();
        trace_enable_i       = 1'b1;
        nc_trace_qualified_i = 1'b1;
        tick();
        start_ack_i = 1'b1;
        tick();
        start_ack_i = 1'b0;
    endtask

    task automatic finish_stop();
        trace_enable_i = 1'b0;
        fifo_empty_i   = 1'b1;
        stop_ack_i     = 1'b1;
        tick();
        tick();
        stop_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_ni               = 1'b0;
        trace_enable_i       = 1'b0;
        nc_trace_qualified_i = 1'b1;
        trigger_trace_off_i  = 1'b0;
        resync_max_i         = '0;
        pkt_valid_i          = 1'b0;
        start_ack_i          = 1'b0;
        stop_ack_i           = 1'b0;
        resync_ack_i         = 1'b0;
        fifo_empty_i         = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({state_o, trace_active_o, start_req_o, stop_req_o, resync_req_o, trace_req_deactivate_o} !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: state=%b act=%b start=%b stop=%b resync=%b deact=%b, required all 0",
                     state_o, trace_active_o, start_req_o, stop_req_o, resync_req_o, trace_req_deactivate_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_basic_on_off();
        trace_enable_i = 1'b1;
        tick();
        tests_run++;
        if (start_req_o !== 1'b1 || state_o !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL basic_start_req: start_req=%b state=%b, required 1/01", start_req_o, state_o);
        end
        tick();
        tick();
        start_ack_i = 1'b1;
        tests_run++;
        if (start_req_o !== 1'b1 || trace_active_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_start_hold: start_req=%b act=%b, required 1/0", start_req_o, trace_active_o);
        end
        tick();
        start_ack_i = 1'b0;
        tests_run++;
        if (trace_active_o !== 1'b1 || state_o !== 2'b10 || start_req_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_active: act=%b state=%b start=%b, required 1/10/0", trace_active_o, state_o, start_req_o);
        end
        trace_enable_i = 1'b0;
        tick();
        tests_run++;
        if (stop_req_o !== 1'b1 || state_o !== 2'b11 || trace_active_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_stop_req: stop_req=%b state=%b act=%b, required 1/11/0", stop_req_o, state_o, trace_active_o);
        end
        stop_ack_i = 1'b1;
        tick();
        stop_ack_i = 1'b0;
        tests_run++;
        if (state_o !== 2'b00 || stop_req_o !== 1'b0 || trace_req_deactivate_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_idle: state=%b stop=%b deact=%b, required 00/0/0", state_o, stop_req_o, trace_req_deactivate_o);
        end
        tick();
        tests_run++;
        if (trace_req_deactivate_o !== 1'b0 || state_o !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL basic_no_deact: deact=%b state=%b, required 0/00", trace_req_deactivate_o, state_o);
        end
    endtask

    task automatic test_trigger_stop();
        int waited_ok;
        goto_active();
        trigger_trace_off_i = 1'b1;
        fifo_empty_i        = 1'b0;
        tick();
        trigger_trace_off_i = 1'b0;
        trace_enable_i      = 1'b0;
        tests_run++;
        if (state_o !== 2'b11 || trace_active_o !== 1'b0 || stop_req_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL trig_stopping: state=%b act=%b stop=%b, required 11/0/1", state_o, trace_active_o, stop_req_o);
        end
        stop_ack_i = 1'b1;
        tick();
        stop_ack_i = 1'b0;
        waited_ok = 1;
        for (int i = 0; i < 4; i++) begin
            if (state_o !== 2'b11 || stop_req_o !== 1'b0 || trace_req_deactivate_o !== 1'b0) waited_ok = 0;
            tick();
        end
        tests_run++;
        if (waited_ok !== 1) begin
            tests_failed++;
            $display("[TB] FAIL trig_wait_fifo: waited_ok=%0d, required 1 (state 11, stop 0 while fifo busy)", waited_ok);
        end
        fifo_empty_i = 1'b1;
        tick();
        tests_run++;
        if (state_o !== 2'b00 || trace_req_deactivate_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL trig_deact_pulse: state=%b deact=%b, required 00/1", state_o, trace_req_deactivate_o);
        end
        tick();
        tests_run++;
        if (trace_req_deactivate_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL trig_deact_one_cycle: deact=%b, required 0", trace_req_deactivate_o);
        end
    endtask

    task automatic test_resync();
        int saw_req;
        resync_max_i = 16'd4;
        goto_active();
        pkt_valid_i = 1'b1;
        tick();
        tick();
        tick();
        tests_run++;
        if (resync_req_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL resync_early: resync=%b after 3 pkts, required 0", resync_req_o);
        end
        tick();
        pkt_valid_i = 1'b0;
        tests_run++;
        if (resync_req_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL resync_hit: resync=%b after 4 pkts, required 1", resync_req_o);
        end
        tick();
        pkt_valid_i = 1'b1;
        tick();
        pkt_valid_i = 1'b0;
        tests_run++;
        if (resync_req_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL resync_hold: resync=%b before ack, required 1", resync_req_o);
        end
        resync_ack_i = 1'b1;
        tick();
        resync_ack_i = 1'b0;
        tests_run++;
        if (resync_req_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL resync_ack: resync=%b after ack, required 0", resync_req_o);
        end
        pkt_valid_i = 1'b1;
        tick();
        tick();
        tests_run++;
        if (resync_req_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL resync_count_pending: resync=%b at count 3, required 0", resync_req_o);
        end
        tick();
        pkt_valid_i = 1'b0;
        tests_run++;
        if (resync_req_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL resync_second_hit: resync=%b at count 4, required 1", resync_req_o);
        end
        resync_ack_i = 1'b1;
        tick();
        resync_ack_i = 1'b0;
        resync_max_i = '0;
        saw_req      = 0;
        pkt_valid_i  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (resync_req_o !== 1'b0) saw_req = 1;
        end
        pkt_valid_i = 1'b0;
        tests_run++;
        if (saw_req !== 0) begin
            tests_failed++;
            $display("[TB] FAIL resync_disabled: saw_req=%0d with max 0, required 0", saw_req);
        end
        finish_stop();
    endtask

    task automatic test_stop_during_starting();
        trace_enable_i = 1'b1;
        tick();
        trace_enable_i = 1'b0;
        tick();
        tick();
        tests_run++;
        if (start_req_o !== 1'b1 || state_o !== 2'b01 || trace_active_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL starting_no_abort: start=%b state=%b act=%b, required 1/01/0", start_req_o, state_o, trace_active_o);
        end
        start_ack_i = 1'b1;
        tick();
        start_ack_i = 1'b0;
        tests_run++;
        if (state_o !== 2'b11 || trace_active_o !== 1'b0 || stop_req_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL starting_to_stopping: state=%b act=%b stop=%b, required 11/0/1", state_o, trace_active_o, stop_req_o);
        end
        stop_ack_i = 1'b1;
        tick();
        stop_ack_i = 1'b0;
        tests_run++;
        if (state_o !== 2'b00 || trace_req_deactivate_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL starting_idle: state=%b deact=%b, required 00/0", state_o, trace_req_deactivate_o);
        end
    endtask

    task automatic test_simultaneous();
        resync_max_i = 16'd4;
        goto_active();
        pkt_valid_i = 1'b1;
        tick();
        tick();
        tick();
        trace_enable_i = 1'b0;
        tick();
        pkt_valid_i = 1'b0;
        tests_run++;
        if (resync_req_o !== 1'b0 || state_o !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL simul_stop_priority: resync=%b state=%b, required 0/11", resync_req_o, state_o);
        end
        finish_stop();
        resync_max_i = '0;
    endtask

    task automatic test_reset_mid_stopping();
        goto_active();
        trigger_trace_off_i = 1'b1;
        fifo_empty_i        = 1'b0;
        tick();
        trigger_trace_off_i = 1'b0;
        trace_enable_i      = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if ({state_o, trace_active_o, start_req_o, stop_req_o, resync_req_o, trace_req_deactivate_o} !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: state=%b act=%b start=%b stop=%b resync=%b deact=%b, required all 0",
                     state_o, trace_active_o, start_req_o, stop_req_o, resync_req_o, trace_req_deactivate_o);
        end
        fifo_empty_i = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        goto_active();
        trace_enable_i = 1'b0;
        tick();
        stop_ack_i = 1'b1;
        tick();
        stop_ack_i = 1'b0;
        tests_run++;
        if (state_o !== 2'b00 || trace_req_deactivate_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_clears_cause: state=%b deact=%b, required 00/0", state_o, trace_req_deactivate_o);
        end
    endtask

    task automatic test_back_to_back();
        goto_active();
        trace_enable_i = 1'b0;
        fifo_empty_i   = 1'b1;
        tick();
        trace_enable_i = 1'b1;
        tick();
        tests_run++;
        if (state_o !== 2'b11 || stop_req_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_go_in_stopping: state=%b stop=%b, required 11/1", state_o, stop_req_o);
        end
        stop_ack_i = 1'b1;
        tick();
        stop_ack_i = 1'b0;
        tests_run++;
        if (state_o !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL b2b_idle: state=%b, required 00", state_o);
        end
        tick();
        tests_run++;
        if (state_o !== 2'b01 || start_req_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_restart: state=%b start=%b, required 01/1", state_o, start_req_o);
        end
        start_ack_i = 1'b1;
        tick();
        start_ack_i = 1'b0;
        finish_stop();
    endtask

    initial begin
        test_reset();
        test_basic_on_off();
        test_trigger_stop();
        test_resync();
        test_stop_during_starting();
        test_simultaneous();
        test_reset_mid_stopping();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
